// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: width defaults, opcode
// field layout, fetch FSM states and next-PC select encodings.
package instr_fetch_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 16;

  // Opcode occupies the top OPCODE_W bits of the instruction word
  localparam int OPCODE_W       = 6;
  localparam int OPCODE_TOP_OFS = 0;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    SKIP = 2'd1,
    JUMP = 2'd2
  } npc_sel_e;

  // A jump always wins; skip only matters on sequential flow
  function automatic npc_sel_e npcSelect(input logic sInc, input logic sSkip);
    if (!sInc) begin
      return JUMP;
    end else if (sSkip) begin
      return SKIP;
    end
    return SEQ;
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC selection: jump target, pc+1 or pc+2, all
// wrapping modulo 2^PC_W.
module next_pc_calc
  import instr_fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            s_inc_i,
  input  logic            s_skip_i,
  input  logic [PC_W-1:0] jr_target_i,
  output logic [PC_W-1:0] next_pc_o
);

  npc_sel_e sel;

  always_comb begin
    sel       = npcSelect(s_inc_i, s_skip_i);
    next_pc_o = pc_i + PC_W'(1);
    case (sel)
      JUMP:    next_pc_o = jr_target_i;
      SKIP:    next_pc_o = pc_i + PC_W'(2);
      default: next_pc_o = pc_i + PC_W'(1);
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: two-state FETCH/ISSUE loop that reads one word
// from instruction memory, holds it until retired, then advances the PC.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEF,
  parameter int          INSTR_W  = INSTR_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_inc,
  input  logic               s_skip,
  input  logic [PC_W-1:0]    jr_target,
  input  logic               exec_done,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               started_q, started_d;
  logic [PC_W-1:0]    nextPc;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc_i        (pc_q),
    .s_inc_i     (s_inc),
    .s_skip_i    (s_skip),
    .jr_target_i (jr_target),
    .next_pc_o   (nextPc)
  );

  // started_q keeps mem_req low until the first clock edge after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= PC_W'(RESET_PC);
      instr_q   <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      started_q <= started_d;
    end
  end

  // A late ack from an abandoned fetch is taken as the RESET_PC word
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    started_d   = 1'b1;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = started_q;
        if (mem_ack) begin
          instr_d = mem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          pc_d    = nextPc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign opcode   = instr_q[INSTR_W-1-OPCODE_TOP_OFS -: OPCODE_W];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter width in bits.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction word width in bits.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 s_inc  input  1  from control unit: 1 = sequential flow, 0 = jump (JR).
REQ-007 s_skip  input  1  from control unit: 1 = skip next instruction (valid only when s_inc=1).
REQ-008 jr_target  input  PC_W  jump destination from register file.
REQ-009 exec_done  input  1  current instruction retired; s_inc, s_skip, jr_target sampled this cycle.
REQ-010 mem_req  output  1  instruction-memory read request.
REQ-011 mem_addr  output  PC_W  instruction-memory read address.
REQ-012 mem_ack  input  1  read data valid on mem_rdata this cycle.
REQ-013 mem_rdata  input  INSTR_W  instruction word from memory.
REQ-014 instr  output  INSTR_W  latched current instruction.
REQ-015 opcode  output  6  instr[INSTR_W-1 -: 6], driven to control unit.
REQ-016 instr_valid  output  1  instr/opcode hold a fetched, unretired instruction.
REQ-017 pc  output  PC_W  address of current instruction.

Function
REQ-018 SHALL implement FSM states FETCH and ISSUE only.
REQ-019 FETCH: mem_req=1, mem_addr=pc, instr_valid=0; mem_req and mem_addr SHALL stay stable until mem_ack.
REQ-020 FETCH with mem_ack=1: instr <= mem_rdata, next state ISSUE; mem_req SHALL be 0 the following cycle.
REQ-021 ISSUE: instr_valid=1, mem_req=0; hold until exec_done=1.
REQ-022 ISSUE with exec_done=1: pc <= next PC, next state FETCH; mem_req SHALL assert the very next cycle (zero-bubble refetch).
REQ-023 Next PC SHALL be: s_inc=0 -> jr_target; s_inc=1,s_skip=0 -> pc+1; s_inc=1,s_skip=1 -> pc+2.
REQ-024 s_inc=0 SHALL take priority over s_skip (s_skip ignored on jump).
REQ-025 PC arithmetic SHALL be modulo 2^PC_W; 2^PC_W-1 +1 -> 0, 2^PC_W-2 +2 -> 0, 2^PC_W-1 +2 -> 1.
REQ-026 exec_done in FETCH SHALL be ignored (no PC change, no state change).
REQ-027 mem_ack in ISSUE SHALL be ignored (instr unchanged).
REQ-028 Minimum instruction period with single-cycle ack SHALL be 2 cycles (FETCH, ISSUE).
REQ-029 opcode SHALL be purely combinational from instr register (no extra latency).

Reset
REQ-030 On reset=1, immediately and without clk: state=FETCH, pc=RESET_PC, instr=0, instr_valid=0.
REQ-031 mem_req SHALL be 0 while reset=1 and SHALL assert on the first rising edge after reset deasserts, mem_addr=RESET_PC.
REQ-032 Reset during an outstanding fetch SHALL abandon it; a late mem_ack from that fetch is not distinguished and is accepted as the RESET_PC fetch.

Structure
REQ-033 Shared package SHALL hold PC_W/INSTR_W defaults, opcode field position/width, the FSM state enum, and next-PC select encodings (SEQ, SKIP, JUMP).
REQ-034 Next-PC computation SHALL live in one combinational sub-module, next_pc_calc (inputs pc, s_inc, s_skip, jr_target; output next PC).
REQ-035 Opcode encodings themselves SHALL remain owned by the control unit; instr_fetch never decodes opcodes.

Verification
REQ-036 Reset, mem_ack one cycle after each mem_req, exec_done with s_inc=1,s_skip=0 x3 -> mem_addr sequence 0,1,2,3; instr_valid high one cycle per instruction.
REQ-037 pc=5, exec_done with s_inc=1,s_skip=1 -> next mem_addr=7; with s_inc=0,s_skip=1,jr_target=0x3A0 -> next mem_addr=0x3A0.
REQ-038 pc=0x3FF, sequential retire -> mem_addr=0x000; pc=0x3FE, skip -> mem_addr=0x000.
REQ-039 mem_ack delayed 4 cycles -> mem_req and mem_addr held constant 4 cycles, instr updates only on ack cycle; exec_done pulsed during wait -> pc unchanged.
REQ-040 Reset asserted mid-ISSUE (pc=0x12, instr_valid=1) -> same-cycle instr_valid=0, mem_req=0, pc=0; after release mem_addr=0.
REQ-041 mem_rdata=0xA123 acked -> opcode=6'b101000 while instr_valid=1; spurious mem_ack with 0xFFFF during ISSUE -> instr stays 0xA123.
